// File: rtl/load_cell_seq.sv
// rtl/load_cell_seq.sv - round-robin A2D conversion sequencer for load cells, steering pot and battery
module load_cell_seq #(
  parameter logic [2:0]  LFT_CH   = 3'd0,
  parameter logic [2:0]  RGHT_CH  = 3'd4,
  parameter logic [2:0]  STEER_CH = 3'd5,
  parameter logic [2:0]  BATT_CH  = 3'd6,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic [1:0]  vld_ch,
  output logic        busy
);

  // DONE is the vld cycle: the sequencer is still busy there, so a request
  // arriving with the final spi_done is held as pending and served one
  // cycle later from IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    GAP   = 3'd2,
    WAIT2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC);

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  slot;
  logic        pending;
  logic [3:0]  gap_cnt;

  logic        launch;
  logic        relaunch;
  logic        first_done;
  logic        second_done;
  logic        gap_last;

  logic        spi_wrt_d;
  logic        vld_d;
  logic        busy_d;

  logic [2:0]  ch_sel;
  logic [15:0] cmd_word;

  // The upper nibble of the A2D reply carries no conversion data.
  logic        unused_rd_hi;
  assign unused_rd_hi = ^spi_rd[15:12];

  // Map the current slot onto its A2D channel and build the command word.
  always_comb begin
    ch_sel = LFT_CH;
    case (slot)
      2'd0:    ch_sel = LFT_CH;
      2'd1:    ch_sel = RGHT_CH;
      2'd2:    ch_sel = STEER_CH;
      default: ch_sel = BATT_CH;
    endcase
    cmd_word = {2'b00, ch_sel, 11'h000};
  end

  // Decode the events that move the conversion along.
  always_comb begin
    gap_last    = (gap_cnt == 4'd1);
    launch      = (state == IDLE) && (nxt || pending);
    relaunch    = (state == GAP) && gap_last;
    first_done  = (state == WAIT1) && spi_done;
    second_done = (state == WAIT2) && spi_done;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; spi_done outside the two WAIT states is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        if (spi_done) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_nxt = WAIT2;
        end
      end
      WAIT2: begin
        if (spi_done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    spi_wrt_d = launch || relaunch;
    vld_d     = second_done;
    busy_d    = (state_nxt != IDLE);
  end

  // Registered outputs, pending flag, gap counter, slot and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_wrt   <= 1'b0;
      spi_cmd   <= 16'h0000;
      vld       <= 1'b0;
      vld_ch    <= 2'd0;
      busy      <= 1'b0;
      pending   <= 1'b0;
      gap_cnt   <= 4'd0;
      slot      <= 2'd0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      spi_wrt <= spi_wrt_d;
      vld     <= vld_d;
      busy    <= busy_d;

      // The command is loaded once per conversion and reused for the
      // second transaction, so it stays stable until the final spi_done.
      if (launch) begin
        spi_cmd <= cmd_word;
      end

      // One-deep request memory; extra requests while set are dropped.
      if (launch) begin
        pending <= 1'b0;
      end else if ((state != IDLE) && nxt) begin
        pending <= 1'b1;
      end

      if (first_done) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      // The first reply belongs to the previous conversion; only the
      // second reply is stored.
      if (second_done) begin
        vld_ch <= slot;
        slot   <= slot + 2'd1;
        case (slot)
          2'd0:    lft_ld    <= spi_rd[11:0];
          2'd1:    rght_ld   <= spi_rd[11:0];
          2'd2:    steer_pot <= spi_rd[11:0];
          default: batt      <= spi_rd[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_cell_seq.sv
// tb/tb_load_cell_seq.sv - randomized self-checking bench for load_cell_seq
module tb_load_cell_seq;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        vld;
  logic [1:0]  vld_ch;
  logic        busy;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_res [4];
  int          exp_slot;
  logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

  int wrt_log [$];

  load_cell_seq #(
    .LFT_CH   (3'd0),
    .RGHT_CH  (3'd4),
    .STEER_CH (3'd5),
    .BATT_CH  (3'd6),
    .GAP_CYC  (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi_done  (spi_done),
    .spi_rd    (spi_rd),
    .spi_wrt   (spi_wrt),
    .spi_cmd   (spi_cmd),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .vld       (vld),
    .vld_ch    (vld_ch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_wrt === 1'b1) wrt_log.push_back(cyc);
  end

  // Reference model: one register per slot, slots visited in order.
  function automatic logic [15:0] exp_cmd(int s);
    logic [2:0] c;
    c = ch_tab[s];
    return {2'b00, c, 11'h000};
  endfunction

  function automatic logic [47:0] exp_all();
    return {exp_res[0], exp_res[1], exp_res[2], exp_res[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    exp_slot = 0;
  endtask

  task automatic model_apply(input logic [15:0] rd);
    exp_res[exp_slot] = rd[11:0];
    exp_slot = (exp_slot + 1) % 4;
  endtask

  // Stimulus helpers: advance to the next falling edge with idle inputs.
  task automatic cycle();
    @(negedge clk);
    nxt      = 1'b0;
    spi_done = 1'b0;
    spi_rd   = 16'($urandom);
  endtask

  task automatic wait_wrt(output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (spi_wrt === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_vld(output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (vld === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  // SPI slave: answer t cycles after the spi_wrt just observed.
  task automatic do_xact(input int t, input logic [15:0] rd, output bit stable);
    logic [15:0] c0;
    c0     = spi_cmd;
    stable = 1'b1;
    for (int i = 0; i < t; i++) begin
      cycle();
      if (spi_cmd !== c0) stable = 1'b0;
    end
    spi_done = 1'b1;
    spi_rd   = rd;
  endtask

  task automatic run_conv(input int t1, input int t2, input logic [15:0] rd2,
                          output int lat, output int d_w1, output int d_w2, output int d_v,
                          output logic [15:0] cmd1, output logic [15:0] cmd2,
                          output bit stable, output bit ok);
    int t0, w1, w2, d1, d2, tv;
    bit ok1, ok2, ok3, s1, s2;
    t0  = cyc;
    nxt = 1'b1;
    wait_wrt(w1, ok1);
    cmd1 = spi_cmd;
    d_w1 = w1 - t0;
    do_xact(t1, 16'($urandom), s1);
    d1 = cyc;
    wait_wrt(w2, ok2);
    cmd2 = spi_cmd;
    d_w2 = w2 - d1;
    do_xact(t2, rd2, s2);
    d2 = cyc;
    wait_vld(tv, ok3);
    d_v    = tv - d2;
    lat    = tv - t0;
    stable = s1 & s2;
    ok     = ok1 & ok2 & ok3;
  endtask

  task automatic do_reset(input int n);
    cycle();
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    nxt      = 1'b1;
    spi_done = 1'b0;
    spi_rd   = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      cycle();
      nxt = 1'b1;
      n_vec++;
      if ({spi_wrt, vld, busy, vld_ch, spi_cmd, lft_ld, rght_ld, steer_pot, batt} !== 69'd0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got wrt=%b vld=%b busy=%b cmd=%h res=%h/%h/%h/%h want all 0",
                 cyc, spi_wrt, vld, busy, spi_cmd, lft_ld, rght_ld, steer_pot, batt);
      end
    end
    rst_n = 1'b1;
    nxt   = 1'b0;
    model_reset();
    cycle();
    n_vec++;
    if ({spi_wrt, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_no_pending got wrt=%b busy=%b want 0 0", spi_wrt, busy);
    end
  endtask

  task automatic test_single();
    int lat, dw1, dw2, dv;
    logic [15:0] c1, c2;
    bit st, ok;
    run_conv(32, 32, 16'hF400, lat, dw1, dw2, dv, c1, c2, st, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_timeout got ok=%b want 1", ok); end
    n_vec++; if (dw1 !== 1) begin n_err++; $display("FAIL single_wrt1 got %0d want 1", dw1); end
    n_vec++; if (dw2 !== GAP + 1) begin n_err++; $display("FAIL single_wrt2 got %0d want %0d", dw2, GAP + 1); end
    n_vec++; if (dv !== 1) begin n_err++; $display("FAIL single_vld_delay got %0d want 1", dv); end
    n_vec++; if (c1 !== exp_cmd(exp_slot)) begin n_err++; $display("FAIL single_cmd got %h want %h", c1, exp_cmd(exp_slot)); end
    n_vec++; if (c2 !== c1) begin n_err++; $display("FAIL single_cmd2 got %h want %h", c2, c1); end
    n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL single_cmd_stable got %b want 1", st); end
    n_vec++; if (vld_ch !== 2'(exp_slot)) begin n_err++; $display("FAIL single_vld_ch got %0d want %0d", vld_ch, exp_slot); end
    model_apply(16'hF400);
    n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
      n_err++; $display("FAIL single_results got %h want %h", {lft_ld, rght_ld, steer_pot, batt}, exp_all());
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_in_vld got %b want 1", busy); end
    cycle();
    n_vec++; if ({vld, busy} !== 2'b00) begin n_err++; $display("FAIL single_after_vld got vld=%b busy=%b want 0 0", vld, busy); end
  endtask

  task automatic test_round_robin();
    logic [11:0] tab [4] = '{12'h400, 12'h300, 12'h800, 12'hA00};
    int lat, dw1, dw2, dv, t1, t2;
    logic [15:0] c1, c2, rd;
    bit st, ok;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      t1 = $urandom_range(3, 20);
      t2 = $urandom_range(3, 20);
      rd = (k < 4) ? {4'($urandom), tab[k]} : 16'($urandom);
      cycle();
      run_conv(t1, t2, rd, lat, dw1, dw2, dv, c1, c2, st, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rr_timeout k=%0d", k); end
      n_vec++; if (c1 !== exp_cmd(exp_slot) || c2 !== c1) begin
        n_err++; $display("FAIL rr_cmd k=%0d got %h/%h want %h", k, c1, c2, exp_cmd(exp_slot));
      end
      n_vec++; if (lat !== t1 + t2 + GAP + 3) begin n_err++; $display("FAIL rr_latency k=%0d got %0d want %0d", k, lat, t1 + t2 + GAP + 3); end
      n_vec++; if (vld_ch !== 2'(exp_slot)) begin n_err++; $display("FAIL rr_vld_ch k=%0d got %0d want %0d", k, vld_ch, exp_slot); end
      model_apply(rd);
      n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
        n_err++; $display("FAIL rr_results k=%0d got %h want %h", k, {lft_ld, rght_ld, steer_pot, batt}, exp_all());
      end
    end
  endtask

  task automatic test_random();
    int lat, dw1, dw2, dv, t1, t2, idle;
    logic [15:0] c1, c2, rd;
    bit st, ok;
    for (int k = 0; k < 8; k++) begin
      idle = $urandom_range(1, 4);
      for (int i = 0; i < idle; i++) begin
        cycle();
        if ($urandom_range(0, 1) == 1) spi_done = 1'b1;
      end
      cycle();
      t1 = $urandom_range(1, 12);
      t2 = $urandom_range(1, 12);
      rd = 16'($urandom);
      run_conv(t1, t2, rd, lat, dw1, dw2, dv, c1, c2, st, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand_timeout k=%0d", k); end
      n_vec++; if (c1 !== exp_cmd(exp_slot) || c2 !== c1 || st !== 1'b1) begin
        n_err++; $display("FAIL rand_cmd k=%0d got %h/%h stable=%b want %h", k, c1, c2, st, exp_cmd(exp_slot));
      end
      n_vec++; if (lat !== t1 + t2 + GAP + 3) begin n_err++; $display("FAIL rand_latency k=%0d got %0d want %0d", k, lat, t1 + t2 + GAP + 3); end
      n_vec++; if (vld_ch !== 2'(exp_slot)) begin n_err++; $display("FAIL rand_vld_ch k=%0d got %0d want %0d", k, vld_ch, exp_slot); end
      model_apply(rd);
      n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
        n_err++; $display("FAIL rand_results k=%0d got %h want %h", k, {lft_ld, rght_ld, steer_pot, batt}, exp_all());
      end
    end
  endtask

  task automatic test_pending();
    int s0, w1, w2, w3, tv;
    bit ok1, ok2, ok3, ok4, ok5, st;
    logic [15:0] rd_a, rd_b, c3;
    rd_a = 16'($urandom);
    rd_b = 16'($urandom);
    cycle();
    s0  = wrt_log.size();
    nxt = 1'b1;
    wait_wrt(w1, ok1);
    nxt = 1'b1;
    cycle(); cycle();
    nxt = 1'b1;
    cycle(); cycle();
    nxt = 1'b1;
    repeat (6) cycle();
    spi_done = 1'b1;
    spi_rd   = 16'($urandom);
    wait_wrt(w2, ok2);
    do_xact(8, rd_a, st);
    wait_vld(tv, ok3);
    model_apply(rd_a);
    wait_wrt(w3, ok4);
    c3 = spi_cmd;
    n_vec++; if (w3 - tv !== 2) begin n_err++; $display("FAIL pend_restart got %0d want 2", w3 - tv); end
    n_vec++; if (c3 !== exp_cmd(exp_slot)) begin n_err++; $display("FAIL pend_cmd got %h want %h", c3, exp_cmd(exp_slot)); end
    do_xact(5, 16'($urandom), st);
    wait_wrt(w2, ok5);
    do_xact(5, rd_b, st);
    wait_vld(tv, ok3);
    model_apply(rd_b);
    n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
      n_err++; $display("FAIL pend_results got %h want %h", {lft_ld, rght_ld, steer_pot, batt}, exp_all());
    end
    repeat (30) cycle();
    n_vec++; if (wrt_log.size() - s0 !== 4) begin
      n_err++; $display("FAIL pend_wrt_count got %0d want 4", wrt_log.size() - s0);
    end
    n_vec++; if ({ok1, ok2, ok3, ok4, ok5, busy} !== 6'b111110) begin
      n_err++; $display("FAIL pend_flow got ok=%b%b%b%b%b busy=%b want 11111 0", ok1, ok2, ok3, ok4, ok5, busy);
    end
  endtask

  task automatic test_coincident();
    int w, d2, tv, w3;
    bit ok1, ok2, ok3, ok4, st;
    logic [15:0] rd_a, rd_b;
    rd_a = 16'($urandom);
    rd_b = 16'($urandom);
    cycle();
    nxt = 1'b1;
    wait_wrt(w, ok1);
    do_xact(4, 16'($urandom), st);
    wait_wrt(w, ok2);
    do_xact(7, rd_a, st);
    nxt = 1'b1;
    d2  = cyc;
    wait_vld(tv, ok3);
    model_apply(rd_a);
    n_vec++; if (tv - d2 !== 1) begin n_err++; $display("FAIL coin_vld got %0d want 1", tv - d2); end
    cycle();
    n_vec++; if ({busy, spi_wrt} !== 2'b00) begin n_err++; $display("FAIL coin_busy_fall got busy=%b wrt=%b want 0 0", busy, spi_wrt); end
    wait_wrt(w3, ok4);
    n_vec++; if (w3 - d2 !== 3) begin n_err++; $display("FAIL coin_restart got %0d want 3", w3 - d2); end
    n_vec++; if (spi_cmd !== exp_cmd(exp_slot)) begin n_err++; $display("FAIL coin_cmd got %h want %h", spi_cmd, exp_cmd(exp_slot)); end
    do_xact(3, 16'($urandom), st);
    wait_wrt(w, ok1);
    do_xact(3, rd_b, st);
    wait_vld(tv, ok2);
    model_apply(rd_b);
    n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all() || ok3 !== 1'b1) begin
      n_err++; $display("FAIL coin_results got %h want %h", {lft_ld, rght_ld, steer_pot, batt}, exp_all());
    end
  endtask

  task automatic test_mid_reset();
    int w, bad, lat, dw1, dw2, dv;
    bit ok, st;
    logic [15:0] c1, c2, rd;
    cycle();
    nxt = 1'b1;
    wait_wrt(w, ok);
    do_xact(6, 16'($urandom), st);
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    model_reset();
    n_vec++; if ({spi_wrt, vld, busy, vld_ch, spi_cmd, lft_ld, rght_ld, steer_pot, batt} !== 69'd0) begin
      n_err++; $display("FAIL midrst_clear got wrt=%b vld=%b busy=%b cmd=%h res=%h/%h/%h/%h want all 0",
                        spi_wrt, vld, busy, spi_cmd, lft_ld, rght_ld, steer_pot, batt);
    end
    bad = 0;
    for (int i = 0; i < GAP + 3; i++) begin
      cycle();
      if (i == 1) spi_done = 1'b1;
      if ({spi_wrt, vld, busy} !== 3'b000) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL midrst_stray got %0d active cycles want 0", bad); end
    cycle();
    rd = 16'($urandom);
    run_conv(5, 5, rd, lat, dw1, dw2, dv, c1, c2, st, ok);
    n_vec++; if (c1 !== 16'h0000 || ok !== 1'b1) begin n_err++; $display("FAIL midrst_cmd got %h ok=%b want 0000", c1, ok); end
    n_vec++; if (vld_ch !== 2'd0) begin n_err++; $display("FAIL midrst_vld_ch got %0d want 0", vld_ch); end
    model_apply(rd);
    n_vec++; if ({lft_ld, rght_ld, steer_pot, batt} !== exp_all()) begin
      n_err++; $display("FAIL midrst_results got %h want %h", {lft_ld, rght_ld, steer_pot, batt}, exp_all());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_pending();
    test_coincident();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
